nice_io_line_writer: RTL
========================

# nice_io_line_writer

Hardware text-stream writer: accepts fixed-width data words over a valid/ready handshake and emits them as ASCII hex text, one byte per cycle. Words are separated by a space, and lines are terminated with a newline. It is the producer end of the newline-delimited text streams that the `io` package's file reader and line parsing consume. The intended use is to feed byte sinks such as trace FIFOs, UART transmitters and simulation dump ports with output that `io::file.readline()` can parse directly.

## Interface
Parameters:
- `DATA_W`, 32: input word width; must be a multiple of 4 and at least 4.
- `WORDS_PER_LINE`, 4: words per line before an automatic end-of-line; must be at least 1.
- `UPPERCASE`, 0: 1 selects hex digits `A`–`F`; 0 selects `a`–`f`.

Ports (clock and reset first):
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: input word valid.
- `in_ready`, output, 1: block accepts a word this cycle.
- `in_data`, input, `DATA_W`: word to print, most significant nibble first.
- `flush`, input, 1: single-cycle request to terminate a partial line.
- `out_valid`, output, 1: `out_byte` is valid.
- `out_ready`, input, 1: sink accepts the byte.
- `out_byte`, output, 8: ASCII character.
- `out_eol`, output, 1: qualifies the final byte of a line (`8'h0a`).
- `busy`, output, 1: high when the state is not IDLE or a flush is pending.
- `words_written`, output, 32: count of words fully emitted; wraps modulo 2^32.

## Operation
- States:
  - IDLE: no byte output.
  - SEP: output `8'h20`.
  - HEX: output the current nibble.
  - CR: output `8'h0d`; present only with the CRLF option.
  - LF: output `8'h0a` with `out_eol` high.
- Registers:
  - `shreg[DATA_W]`: word being printed.
  - `nib_cnt`: counts `DATA_W/4` down to 1.
  - `col`: words already on the current line, range 0..`WORDS_PER_LINE-1`.
  - `flush_pend`: pending flush request.
- `in_ready = (state==IDLE) && !flush_pend && !rst`.
- Accept (`in_valid && in_ready`): load `shreg` and set `nib_cnt=DATA_W/4`. Next state is SEP if `col!=0`, otherwise HEX.
- SEP: on handshake, go to HEX.
- HEX:
  - `out_byte = nib<10 ? 8'h30+nib : (UPPERCASE ? 8'h41 : 8'h61)+nib-10`, where `nib = shreg[DATA_W-1 -: 4]`.
  - On handshake, shift `shreg` left by 4 and decrement `nib_cnt`.
  - When the last nibble is transferred: increment `words_written`. If `col==WORDS_PER_LINE-1`, set `col<=0` and go to the EOL entry state. Otherwise increment `col` and go to IDLE.
- EOL entry state is CR when the CRLF option is compiled in, otherwise LF. CR goes to LF on handshake; LF goes to IDLE on handshake.
- `flush` sets `flush_pend` in any state.
- In IDLE with `flush_pend`:
  - If `col!=0`: set `col<=0`, clear `flush_pend`, go to the EOL entry state.
  - If `col==0`: clear `flush_pend` and emit nothing; a flush never produces an empty line.
  - Flush has priority over `in_valid`.
- The output is Moore-style: `out_valid = state!=IDLE`. `out_byte` and `out_eol` stay stable while `out_valid && !out_ready`. There is no combinational path from `out_ready` to `out_valid`.

## Timing
- Reset values:
  - `out_valid=0`, `out_eol=0`, `out_byte=8'h00`, `in_ready=0`.
  - `busy=0`, `words_written=0`, `col=0`, `flush_pend=0`, state IDLE.
- `in_ready=1` in the first cycle after `rst` deasserts.
- Latency: a word accepted at cycle t produces its first byte, `out_valid`, at t+1.
- Throughput with `out_ready` held high:
  - A word costs 1 accept cycle plus `DATA_W/4` HEX cycles, plus 1 SEP cycle when `col!=0` at accept.
  - A line end adds 1 cycle (LF), or 2 cycles with CRLF.
- A flush arriving in the same cycle as an accept is serviced after that word completes.
- Reset mid-word or mid-line aborts immediately. No partial-line terminator is emitted, and `words_written` returns to 0.
- Backpressure stalls state, `shreg` and counters indefinitely; no byte is dropped or duplicated.

## Configuration
- `NICE_IO_LINE_WRITER_CRLF_EN` defined: line terminator is `8'h0d 8'h0a`. `out_eol` is asserted only on the `8'h0a` byte.
- Macro undefined: terminator is `8'h0a` only, and the CR state is not compiled.

## Structure
- Shared package `nice_io_hw_pkg` holds:
  - The state enum.
  - Constants `ASCII_SP=8'h20`, `ASCII_CR=8'h0d`, `ASCII_LF=8'h0a`.
  - Function `nibble_to_ascii(logic [3:0] n, bit upper)`.
- No sub-module is used. Nibble conversion is the package function. A single module holds the FSM and datapath.

## Test plan
- `WORDS_PER_LINE=2`: send `32'hDEADBEEF` then `32'h00000001` with `out_ready=1` → exact bytes "deadbeef 00000001\n". `out_eol` is high only on `8'h0a`. `words_written=2`.
- Send one word `32'h0000000A`, then pulse `flush` → "0000000a\n". A second `flush` with `col==0` → no bytes and `busy` drops the next cycle.
- Random `out_ready` (50%) over 100 random words → byte stream matches the reference model with no drops or duplicates. `out_byte` is stable during every stall.
- `UPPERCASE=1`, word `32'hABCDEF12` → "ABCDEF12" followed by a separator or terminator according to `col`.
- `NICE_IO_LINE_WRITER_CRLF_EN` defined, `WORDS_PER_LINE=1`, word `32'h1` → "00000001\r\n". `out_eol` is high only on `8'h0a`.
- Assert `rst` after 3 nibbles of `32'h12345678` → `out_valid=0` the next cycle and `words_written=0`. The next word starts a fresh line with no leading space.

Source files
------------

// File: rtl/nice_io_hw_pkg.sv
// Shared definitions for the nice_io hardware text writers: FSM state
// encoding, ASCII control constants and the nibble-to-hex helper.
// Build option: NICE_IO_LINE_WRITER_CRLF_EN adds the CR state so lines end
// in "\r\n" instead of "\n".
package nice_io_hw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEP  = 3'd1,
        ST_HEX  = 3'd2,
`ifdef NICE_IO_LINE_WRITER_CRLF_EN
        ST_CR   = 3'd3,
`endif
        ST_LF   = 3'd4
    } line_state_e;

    // First state of a line terminator sequence.
`ifdef NICE_IO_LINE_WRITER_CRLF_EN
    localparam line_state_e ST_EOL_ENTRY = ST_CR;
`else
    localparam line_state_e ST_EOL_ENTRY = ST_LF;
`endif

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0d;
    localparam logic [7:0] ASCII_LF = 8'h0a;

    // Map a 4-bit value to its ASCII hex digit, upper or lower case letters.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n, input bit upper);
        logic [7:0] n8;
        n8 = {4'h0, n};
        if (n < 4'd10) begin
            return 8'h30 + n8;
        end
        return (upper ? 8'h41 : 8'h61) + n8 - 8'd10;
    endfunction

endpackage

// File: rtl/nice_io_line_writer.sv
// nice_io_line_writer: prints DATA_W-bit words as ASCII hex, one byte per
// cycle, words separated by a space and lines ended by a newline after
// WORDS_PER_LINE words or on a flush request. Output is Moore-style so the
// byte sink's ready never feeds back into out_valid combinationally.
// Build option: define NICE_IO_LINE_WRITER_CRLF_EN for "\r\n" terminators;
// out_eol still marks only the final 8'h0a byte.
module nice_io_line_writer
    import nice_io_hw_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int UPPERCASE      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_eol,
    output logic              busy,
    output logic [31:0]       words_written
);

    localparam int NIBBLES = DATA_W / 4;
    localparam int NIB_W   = $clog2(NIBBLES + 1);
    localparam int COL_W   = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

    localparam logic [NIB_W-1:0] NIB_LOAD = NIB_W'(NIBBLES);
    localparam logic [NIB_W-1:0] NIB_ONE  = NIB_W'(1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WORDS_PER_LINE - 1);
    localparam logic [COL_W-1:0] COL_ZERO = '0;
    localparam bit               UPPER    = (UPPERCASE != 0);

    line_state_e       state,      state_nxt;
    logic [DATA_W-1:0] shreg,      shreg_nxt;
    logic [NIB_W-1:0]  nib_cnt,    nib_cnt_nxt;
    logic [COL_W-1:0]  col,        col_nxt;
    logic              flush_pend, flush_pend_nxt;
    logic [31:0]       word_cnt,   word_cnt_nxt;

    logic in_hs;
    logic out_hs;
    logic last_nib;

    assign in_ready      = (state == ST_IDLE) && !flush_pend && !rst;
    assign out_valid     = (state != ST_IDLE);
    assign busy          = (state != ST_IDLE) || flush_pend;
    assign words_written = word_cnt;

    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign last_nib = (nib_cnt == NIB_ONE);

    // Next-state and datapath update for the line-printing FSM.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned and infers a latch.
        state_nxt      = state;
        shreg_nxt      = shreg;
        nib_cnt_nxt    = nib_cnt;
        col_nxt        = col;
        flush_pend_nxt = flush_pend | flush;
        word_cnt_nxt   = word_cnt;

        case (state)
            ST_IDLE: begin
                if (flush_pend) begin
                    // A flush on an empty line is simply dropped; a new
                    // flush arriving this very cycle stays pending.
                    flush_pend_nxt = flush;
                    if (col != COL_ZERO) begin
                        col_nxt   = COL_ZERO;
                        state_nxt = ST_EOL_ENTRY;
                    end
                end else if (in_hs) begin
                    shreg_nxt   = in_data;
                    nib_cnt_nxt = NIB_LOAD;
                    state_nxt   = (col != COL_ZERO) ? ST_SEP : ST_HEX;
                end
            end

            ST_SEP: begin
                if (out_hs) begin
                    state_nxt = ST_HEX;
                end
            end

            ST_HEX: begin
                if (out_hs) begin
                    shreg_nxt   = shreg << 4;
                    nib_cnt_nxt = nib_cnt - NIB_ONE;
                    if (last_nib) begin
                        word_cnt_nxt = word_cnt + 32'd1;
                        if (col == COL_LAST) begin
                            col_nxt   = COL_ZERO;
                            state_nxt = ST_EOL_ENTRY;
                        end else begin
                            col_nxt   = col + COL_W'(1);
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end

`ifdef NICE_IO_LINE_WRITER_CRLF_EN
            ST_CR: begin
                if (out_hs) begin
                    state_nxt = ST_LF;
                end
            end
`endif

            ST_LF: begin
                if (out_hs) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any partial word or line silently.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            nib_cnt    <= '0;
            col        <= COL_ZERO;
            flush_pend <= 1'b0;
            word_cnt   <= 32'd0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            nib_cnt    <= nib_cnt_nxt;
            col        <= col_nxt;
            flush_pend <= flush_pend_nxt;
            word_cnt   <= word_cnt_nxt;
        end
    end

    // Output byte decoded purely from registered state, so it holds during stalls.
    always_comb begin
        out_byte = 8'h00;
        out_eol  = 1'b0;
        case (state)
            ST_SEP: out_byte = ASCII_SP;
            ST_HEX: out_byte = nibble_to_ascii(shreg[DATA_W-1 -: 4], UPPER);
`ifdef NICE_IO_LINE_WRITER_CRLF_EN
            ST_CR:  out_byte = ASCII_CR;
`endif
            ST_LF: begin
                out_byte = ASCII_LF;
                out_eol  = 1'b1;
            end
            default: out_byte = 8'h00;
        endcase
    end

endmodule
